// File: rtl/spi_sensor_scheduler_if.sv
// Avalon-MM register port of the SPI sensor scheduler.
// The fabric side uses the master modport and the scheduler uses the slave modport.
interface spi_sensor_scheduler_if;
  logic [7:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, write, writedata, read, input readdata, waitrequest);
  modport slave  (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/spi_sensor_scheduler.sv
// Time-multiplexes one 16-bit SPI master over NUMBER_OF_SENSORS current sensors.
// Each frame tick walks the enabled sensors and latches their 13-bit readings.
module spi_sensor_scheduler #(
  parameter int NUMBER_OF_SENSORS = 2,
  parameter int CLOCK_SPEED_HZ    = 50_000_000,
  parameter int UPDATE_FREQUENCY  = 1_000,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  spi_sensor_scheduler_if.slave        bus,
  output logic                         spi_start,
  input  logic                         spi_ssel_i,
  input  logic                         spi_rx_valid,
  input  logic [15:0]                  spi_rx_data,
  output logic [NUMBER_OF_SENSORS-1:0] ss_n_o
);
  localparam int N  = NUMBER_OF_SENSORS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] PERIOD_RST = 32'(CLOCK_SPEED_HZ / UPDATE_FREQUENCY);

  typedef enum logic [2:0] {IDLE, START, WAIT_SEL, WAIT_DATA, STORE, WAIT_IDLE} state_t;

  state_t        state;
  logic          enable, tick, pending, sel_en, rd_phase;
  logic [N-1:0]  mask, snap;
  logic [31:0]   period, pcnt;
  logic [12:0]   result [N];
  logic [31:0]   frame_cnt, err_cnt, to_cnt, ovr_cnt;
  logic [IW-1:0] idx;
  logic [TW-1:0] wcnt;
  logic [15:0]   rx_word;
  logic [31:0]   rd_mux;
  logic          adv, tmo, clr_cnt, timed_out;
  logic [IW:0]   first_hit, next_hit;

  // {found, index} of the lowest set bit of v at or above position from
  function automatic logic [IW:0] first_set(input logic [N-1:0] v, input int from);
    logic [IW:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i] && i >= from) r = {1'b1, IW'(i)};
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign first_hit = first_set(mask, 0);
  assign next_hit  = first_set(snap, int'(idx) + 1);
  assign clr_cnt   = bus.write && bus.address >= 8'h43 && bus.address <= 8'h46;
  assign timed_out = (wcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      mask   <= '1;
      period <= PERIOD_RST;
    end else if (bus.write) begin
      case (bus.address)
        8'h40:   enable <= bus.writedata[0];
        8'h41:   mask   <= bus.writedata[N-1:0];
        8'h42:   period <= (bus.writedata < 32'd64) ? 32'd64 : bus.writedata;
        default: ;
      endcase
    end
  end

  // >= rather than == so a shrinking period write cannot strand the counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt >= period - 32'd1) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + 32'd1;
      tick <= 1'b0;
    end
  end

  // adv: leave the current sensor, either normally or on a wait timeout
  always_comb begin
    adv = 1'b0;
    tmo = 1'b0;
    case (state)
      WAIT_SEL:  tmo = spi_ssel_i && timed_out;
      WAIT_DATA: tmo = !spi_rx_valid && timed_out;
      WAIT_IDLE: begin
        adv = spi_ssel_i;
        tmo = !spi_ssel_i && timed_out;
      end
      default: ;
    endcase
    adv = adv | tmo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      snap      <= '0;
      sel_en    <= 1'b0;
      spi_start <= 1'b0;
      wcnt      <= '0;
      pending   <= 1'b0;
      rx_word   <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      to_cnt    <= '0;
      ovr_cnt   <= '0;
      for (int i = 0; i < N; i++) result[i] <= '0;
    end else begin
      spi_start <= 1'b0;
      if (!enable) pending <= 1'b0;
      else if (tick && state != IDLE) begin
        pending <= 1'b1;
        ovr_cnt <= sat_inc(ovr_cnt);
      end

      case (state)
        IDLE: if (tick || pending) begin
          pending <= 1'b0;
          if (first_hit[IW]) begin
            snap  <= mask;
            idx   <= first_hit[IW-1:0];
            state <= START;
          end else begin
            frame_cnt <= sat_inc(frame_cnt);
          end
        end
        START: begin
          spi_start <= 1'b1;
          sel_en    <= 1'b1;
          wcnt      <= '0;
          state     <= WAIT_SEL;
        end
        WAIT_SEL:
          if (!spi_ssel_i) begin
            wcnt  <= '0;
            state <= WAIT_DATA;
          end else if (!adv) wcnt <= wcnt + TW'(1);
        WAIT_DATA:
          if (spi_rx_valid) begin
            rx_word <= spi_rx_data;
            state   <= STORE;
          end else if (!adv) wcnt <= wcnt + TW'(1);
        STORE: begin
          if (!rx_word[15]) result[idx] <= rx_word[12:0];
          else              err_cnt     <= sat_inc(err_cnt);
          wcnt  <= '0;
          state <= WAIT_IDLE;
        end
        WAIT_IDLE: if (!adv) wcnt <= wcnt + TW'(1);
        default: state <= IDLE;
      endcase

      if (adv) begin
        wcnt   <= '0;
        sel_en <= 1'b0;
        if (tmo) to_cnt <= sat_inc(to_cnt);
        if (!enable) state <= IDLE;
        else if (next_hit[IW]) begin
          idx   <= next_hit[IW-1:0];
          state <= START;
        end else begin
          frame_cnt <= sat_inc(frame_cnt);
          state     <= IDLE;
        end
      end

      if (clr_cnt) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
        to_cnt    <= '0;
        ovr_cnt   <= '0;
      end
    end
  end

  // Combinational so an async reset releases the sensor inside the reset cycle
  always_comb begin
    ss_n_o = '1;
    if (state != IDLE && sel_en) ss_n_o[idx] = spi_ssel_i;
  end

  always_comb begin
    rd_mux = 32'hDEAD_BEEF;
    if ({24'd0, bus.address} < 32'(N)) rd_mux = {19'd0, result[bus.address[IW-1:0]]};
    else begin
      case (bus.address)
        8'h40:   rd_mux = {31'd0, enable};
        8'h41:   rd_mux = 32'(mask);
        8'h42:   rd_mux = period;
        8'h43:   rd_mux = frame_cnt;
        8'h44:   rd_mux = err_cnt;
        8'h45:   rd_mux = to_cnt;
        8'h46:   rd_mux = ovr_cnt;
        8'h47:   rd_mux = {16'd0, 8'(idx), 7'd0, state != IDLE};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_phase     <= 1'b0;
      bus.readdata <= '0;
    end else if (bus.read && !rd_phase) begin
      rd_phase     <= 1'b1;
      bus.readdata <= rd_mux;
    end else begin
      rd_phase <= 1'b0;
    end
  end

  assign bus.waitrequest = bus.read && !rd_phase;
endmodule

// File: tb/tb_spi_sensor_scheduler.sv
// Bench for spi_sensor_scheduler: register table, directed frame scenarios and
// randomized frames checked against a transfer-level scoreboard.
module tb_spi_sensor_scheduler;
  localparam int N = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          spi_start;
  logic          spi_ssel_i = 1'b1;
  logic          spi_rx_valid = 1'b0;
  logic [15:0]   spi_rx_data = '0;
  logic [N-1:0]  ss_n_o;

  spi_sensor_scheduler_if bus();

  spi_sensor_scheduler #(.NUMBER_OF_SENSORS(N)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .spi_start(spi_start), .spi_ssel_i(spi_ssel_i), .spi_rx_valid(spi_rx_valid),
    .spi_rx_data(spi_rx_data), .ss_n_o(ss_n_o)
  );

  always #5 clock = ~clock;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // sensor model knobs and scoreboard
  bit          no_sel = 1'b0, rand_mode = 1'b0;
  int          xfer_len = 16;
  logic [15:0] resp_word [N];
  logic [12:0] exp_res [N];
  int          exp_err = 0;
  int          log_q[$], start_t[$];
  int          m_sidx;
  logic [15:0] m_word;
  int          multi_low = 0, ss0_low = 0, any_low = 0;

  initial for (int i = 0; i < N; i++) exp_res[i] = '0;

  always begin
    @(posedge clock); #1;
    if (spi_start && !reset) begin
      start_t.push_back(cyc);
      if (!no_sel) begin
        repeat (2) @(posedge clock);
        #1 spi_ssel_i = 1'b0;
        #1 m_sidx = -1;
        for (int j = 0; j < N; j++) if (!ss_n_o[j]) m_sidx = j;
        log_q.push_back(m_sidx);
        repeat (xfer_len) @(posedge clock);
        #1;
        m_word = rand_mode ? 16'($urandom_range(0, 65535)) :
                 (m_sidx >= 0 ? resp_word[m_sidx] : 16'h0);
        if (m_sidx >= 0) begin
          if (m_word[15]) exp_err++;
          else exp_res[m_sidx] = m_word[12:0];
        end
        spi_rx_data  = m_word;
        spi_rx_valid = 1'b1;
        @(posedge clock);
        #1 spi_rx_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 spi_ssel_i = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if ($countones(~ss_n_o) > 1) multi_low <= multi_low + 1;
    if (!ss_n_o[0]) ss0_low <= ss0_low + 1;
    if (ss_n_o != '1) any_low <= any_low + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic avw(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  task automatic avr(input logic [7:0] a, output logic [31:0] d, output logic w1, output logic w2);
    @(negedge clock);
    bus.address = a; bus.read = 1'b1;
    #1 w1 = bus.waitrequest;
    @(negedge clock);
    w2 = bus.waitrequest; d = bus.readdata; bus.read = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    logic w1, w2;
    avr(a, d, w1, w2);
  endtask

  task automatic wait_frames(input logic [31:0] target, input string name);
    logic [31:0] f;
    int n;
    n = 0;
    f = '0;
    do begin rd(8'h43, f); n++; end while (f < target && n < 5000);
    check(name, 32'(f >= target), 32'd1);
  endtask

  typedef struct packed {logic wr; logic [7:0] addr; logic [31:0] data; logic [31:0] exp;} vec_t;
  vec_t vecs[$];
  task automatic addv(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] d;
    logic w1, w2;
    int exp_q[$];
    int n0, maxgap;
    logic [N-1:0] m;

    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    for (int i = 0; i < N; i++) resp_word[i] = 16'h0123;
    repeat (3) @(negedge clock);
    check("rst_ss_n", 32'(ss_n_o), 32'h3);
    check("rst_start", 32'(spi_start), 0);
    check("rst_wait", 32'(bus.waitrequest), 0);
    check("rst_rdata", bus.readdata, 0);
    reset = 1'b0;

    addv(0, 8'h00, 0, 0);            addv(0, 8'h01, 0, 0);
    addv(0, 8'h02, 0, 32'hDEADBEEF); addv(0, 8'h40, 0, 0);
    addv(0, 8'h41, 0, 3);            addv(0, 8'h42, 0, 50000);
    addv(0, 8'h43, 0, 0);            addv(0, 8'h44, 0, 0);
    addv(0, 8'h45, 0, 0);            addv(0, 8'h46, 0, 0);
    addv(0, 8'h47, 0, 0);            addv(0, 8'h50, 0, 32'hDEADBEEF);
    addv(1, 8'h42, 10, 0);           addv(0, 8'h42, 0, 64);
    addv(1, 8'h42, 1000, 0);         addv(0, 8'h42, 0, 1000);
    addv(1, 8'h41, 32'hFFFFFFFC, 0); addv(0, 8'h41, 0, 0);
    addv(1, 8'h41, 3, 0);            addv(0, 8'h41, 0, 3);
    addv(1, 8'h00, 32'h1234, 0);     addv(0, 8'h00, 0, 0);
    addv(1, 8'h50, 5, 0);            addv(0, 8'h50, 0, 32'hDEADBEEF);
    foreach (vecs[i]) begin
      if (vecs[i].wr) avw(vecs[i].addr, vecs[i].data);
      else begin
        avr(vecs[i].addr, d, w1, w2);
        check($sformatf("reg_%02h", vecs[i].addr), d, vecs[i].exp);
        check("wait_first", 32'(w1), 1);
        check("wait_second", 32'(w2), 0);
      end
    end

    // two sensors, period 1000, both return 0x0123
    log_q.delete(); start_t.delete();
    avw(8'h40, 1);
    wait_frames(1, "f1_reached");
    check("f1_nxfer", log_q.size(), 2);
    check("f1_order0", log_q[0], 0);
    check("f1_order1", log_q[1], 1);
    rd(8'h00, d); check("f1_res0", d, 32'h123);
    rd(8'h01, d); check("f1_res1", d, 32'h123);
    rd(8'h43, d); check("f1_frames", d, 1);
    wait_frames(2, "f2_reached");
    avw(8'h40, 0);
    check("f2_nstart", start_t.size(), 4);
    check("f2_spacing", start_t[2] - start_t[0], 1000);

    // sensor 1 reports an error frame
    resp_word[0] = 16'h0456; resp_word[1] = 16'h8ABC;
    avw(8'h44, 0);
    avw(8'h40, 1);
    wait_frames(2, "err_reached");
    avw(8'h40, 0);
    repeat (50) @(negedge clock);
    rd(8'h00, d); check("err_res0", d, 32'h456);
    rd(8'h01, d); check("err_res1", d, 32'h123);
    rd(8'h44, d); check("err_count", d, 2);

    // mask 0b10 then an empty mask
    resp_word[1] = 16'h0777;
    avw(8'h44, 0); avw(8'h41, 2);
    log_q.delete(); n0 = ss0_low;
    avw(8'h40, 1);
    wait_frames(1, "m2_reached");
    avw(8'h40, 0);
    check("m2_nxfer", log_q.size(), 1);
    check("m2_sensor", log_q[0], 1);
    check("m2_ss0_quiet", ss0_low - n0, 0);
    rd(8'h01, d); check("m2_res1", d, 32'h777);
    avw(8'h44, 0); avw(8'h41, 0);
    start_t.delete();
    avw(8'h40, 1);
    wait_frames(1, "m0_reached");
    avw(8'h40, 0);
    rd(8'h43, d); check("m0_frames", d, 1);
    check("m0_nstart", start_t.size(), 0);

    // slave select never asserted: both sensors time out
    no_sel = 1'b1;
    avw(8'h41, 3); avw(8'h42, 5000); avw(8'h44, 0);
    start_t.delete(); n0 = any_low;
    avw(8'h40, 1);
    wait_frames(1, "to_reached");
    avw(8'h40, 0);
    rd(8'h45, d); check("to_count", d, 2);
    check("to_nstart", start_t.size(), 2);
    check("to_ss_high", any_low - n0, 0);
    no_sel = 1'b0;

    // transfers longer than the period
    xfer_len = 75;
    avw(8'h41, 1); avw(8'h42, 64); avw(8'h44, 0);
    start_t.delete();
    avw(8'h40, 1);
    repeat (700) @(negedge clock);
    avw(8'h40, 0);
    repeat (200) @(negedge clock);
    rd(8'h46, d); check("ovr_nonzero", 32'(d != 0), 1);
    rd(8'h43, d); check("ovr_frames", 32'(d >= 6), 1);
    maxgap = 0;
    for (int i = 1; i < start_t.size(); i++)
      if (start_t[i] - start_t[i-1] > maxgap) maxgap = start_t[i] - start_t[i-1];
    check("ovr_back_to_back", 32'(maxgap <= 90), 1);
    avw(8'h44, 0);
    for (int a = 8'h43; a <= 8'h46; a++) begin
      rd(8'(a), d); check($sformatf("clr_%02h", a), d, 0);
    end
    xfer_len = 16;

    // randomized masks and responses against the scoreboard
    rand_mode = 1'b1;
    avw(8'h42, 300);
    for (int r = 0; r < 8; r++) begin
      m = N'($urandom_range(0, (1 << N) - 1));
      avw(8'h41, 32'(m)); avw(8'h44, 0);
      exp_err = 0; log_q.delete();
      avw(8'h40, 1);
      wait_frames(1, "rnd_reached");
      avw(8'h40, 0);
      repeat (20) @(negedge clock);
      exp_q.delete();
      for (int i = 0; i < N; i++) if (m[i]) exp_q.push_back(i);
      check("rnd_nxfer", log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) check("rnd_order", log_q[i], exp_q[i]);
      for (int i = 0; i < N; i++) begin
        rd(8'(i), d); check("rnd_result", d, 32'(exp_res[i]));
      end
      rd(8'h44, d); check("rnd_errors", d, exp_err);
      rd(8'h43, d); check("rnd_frames", d, 1);
    end
    rand_mode = 1'b0;

    // reset in the middle of a long transfer
    xfer_len = 200;
    avw(8'h41, 1); avw(8'h42, 64);
    avw(8'h40, 1);
    n0 = 0;
    while (spi_ssel_i && n0 < 500) begin @(negedge clock); n0++; end
    check("rst_xfer_began", 32'(spi_ssel_i), 0);
    repeat (20) @(negedge clock);
    rd(8'h47, d); check("rst_busy_pre", d, 1);
    check("rst_ss_pre", 32'(ss_n_o), 32'h2);
    reset = 1'b1;
    #1 check("rst_ss_async", 32'(ss_n_o), 32'h3);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n0 = start_t.size();
    rd(8'h47, d); check("rst_status", d, 0);
    rd(8'h40, d); check("rst_enable", d, 0);
    rd(8'h00, d); check("rst_result", d, 0);
    repeat (300) @(negedge clock);
    check("rst_no_start", start_t.size(), n0);
    check("ss_one_hot", multi_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
